// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one 32-bit adder among NREQ
// requesters, with a single-entry result register tagged by requester ID.
module ALUsum (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a + b;
endmodule

module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_a,
  input  logic [32*NREQ-1:0]  req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_sum,
  output logic                rsp_ovf,
  output logic [IDW-1:0]      rsp_id
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [31:0]     sum_q, sum_d;
  logic            ovf_q, ovf_d;
  logic [IDW-1:0]  id_q, id_d;

  logic            can_accept;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  sel;
  logic [31:0]     op_a, op_b, add_y;
  logic            xfer;

  assign can_accept = (state_q == EMPTY) | (rsp_ready & rsp_valid);

  // Search order ptr, ptr+1, ... wrapping; the first hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && req_valid[i] &&
            ((int'(ptr_q) + k == i) ||
             (int'(ptr_q) + k == i + NREQ))) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n & can_accept & gnt_vld &
                     (gnt_id == IDW'(i));
    end
  end

  assign xfer = |(req_valid & req_ready);
  assign sel  = gnt_vld ? gnt_id : ptr_q;

  always_comb begin
    op_a = req_a[31:0];
    op_b = req_b[31:0];
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        op_a = req_a[32*i +: 32];
        op_b = req_b[32*i +: 32];
      end
    end
  end

  ALUsum u_add (
    .a (op_a),
    .b (op_b),
    .y (add_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)           state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    id_d  = id_q;
    if (xfer) begin
      sum_d = add_y;
      ovf_d = (op_a[31] == op_b[31]) & (add_y[31] != op_a[31]);
      id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      id_q  <= '0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      id_q  <= id_d;
    end
  end

  assign rsp_sum = sum_q;
  assign rsp_ovf = ovf_q;
  assign rsp_id  = id_q;

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit adder (ALUsum instance, y = a+b) among NREQ requesters.
- Examples of requesters: PC+4, branch-target, load/store address generation, or a multicycle execute unit.
- Each requester offers an operand pair with a valid/ready handshake. The winner's pair is added, and the result is held in a single-entry output register with its requester ID until the consumer takes it.
- Sits in the datapath between the operand sources and the shared adder. Lets the core use one adder for several low-rate additions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID (must satisfy 2^IDW >= NREQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle. At most one bit is high.
- req_a  input  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- req_b  input  32*NREQ  operand B; requester i uses bits [32i+31:32i].
- rsp_valid  output  1  output register holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_sum  output  32  registered sum, modulo 2^32.
- rsp_ovf  output  1  registered signed overflow of the sum.
- rsp_id  output  IDW  registered index of the requester that produced rsp_sum.

Behaviour:
- Reset (async assert, any cycle):
  - rsp_valid=0, rsp_sum=0, rsp_ovf=0, rsp_id=0.
  - Round-robin pointer ptr=0; FSM goes to EMPTY.
  - Any held result is discarded.
  - req_ready is 0 while rst_n is low.
- FSM states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | (rsp_ready & rsp_valid).
- Grant (combinational):
  - If can_accept, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - req_ready[i]=1 only for the granted i. req_ready may depend on req_valid.
  - No valid request, or can_accept=0: req_ready is all zeros.
- Transfer occurs on a rising edge where req_valid[g] & req_ready[g]. On that edge:
  - rsp_sum <= a_g + b_g (from the shared adder).
  - rsp_ovf <= (a_g[31]==b_g[31]) & (sum[31]!=a_g[31]).
  - rsp_id <= g; state <= FULL; ptr <= (g+1) mod NREQ.
- Pointer update: ptr changes only on a transfer.
- Drain: rsp_valid & rsp_ready with no new transfer -> state <= EMPTY. rsp_sum, rsp_ovf and rsp_id hold their old values.
- Simultaneous drain and transfer: the output register is overwritten and state stays FULL. This gives one result per cycle when rsp_ready is held high.
- Latency:
  - Result is visible one cycle after acceptance (edge k accept, rsp_valid=1 after edge k).
  - Minimum request-to-request spacing is 1 cycle.
- Backpressure: FULL & !rsp_ready -> output register and ptr frozen, all req_ready=0.
- Requester contract:
  - Hold req_valid, req_a and req_b stable until accepted.
  - The arbiter does not capture unaccepted operands.
- Fairness: a continuously asserted request is granted within NREQ transfers.
- Arithmetic:
  - The carry-out is discarded.
  - The adder input mux selects the granted pair. With no grant it selects requester ptr; the adder output is then ignored.

Test Plan:
- Single request: reset, then req_valid=0001, a0=5, b0=7, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_sum=12, rsp_id=0, rsp_ovf=0; ptr=1.
- All requesting, rsp_ready=1: req_valid=1111 held for 8 cycles, operands a_i=i, b_i=100 -> grants in order 0,1,2,3,0,1,2,3; rsp_sum sequence 100,101,102,103 repeating; one result per cycle.
- Backpressure: FULL with rsp_ready=0 for 3 cycles, req_valid=0110 -> req_ready=0 for all 3 cycles and rsp_sum stable. On the cycle rsp_ready=1, requester 1 is granted (ptr=1 after the reset-state grant of 0) and the new result appears on the next cycle.
- Overflow and wrap:
  - 0x7FFFFFFF+1 -> rsp_sum=0x80000000, rsp_ovf=1.
  - 0xFFFFFFFF+1 -> rsp_sum=0, rsp_ovf=0.
  - 0x80000000+0x80000000 -> rsp_sum=0, rsp_ovf=1.
- Reset mid-operation: FULL with rsp_sum=0x1234 and ptr=2, assert rst_n=0 between clock edges -> rsp_valid=0, rsp_sum=0 and req_ready=0 immediately. After release, req_valid=1111 grants requester 0.
- Pointer skip: ptr=1, req_valid=1001 -> requester 3 is granted first, then requester 0; ptr ends at 1.
